if_fetch_unit: RTL

- Instruction-fetch stage that consumes the pipeline control unit's redirect, flush and halt outputs (pc_op, b_jmp, if_flush, halt, overflow_error_warning).
- Owns the PC and the instruction-memory request/response handshake, and loads the IF/ID pipeline register.
- Sits between instruction memory and decode, on the opposite end of the control interface from the control unit.

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_unit_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, the imem request/response handshake,
// a one-entry skid buffer for responses that land during a stall, and IF/ID.
module if_fetch_unit #(
   parameter int                 ADDR_W    = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 16'hF000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pc_op,
   input  logic                b_jmp,
   input  logic                if_flush,
   input  logic                halt,
   input  logic                overflow_error_warning,
   input  logic                stall,
   input  logic [ADDR_W-1:0]   id_pc_plus2,
   input  logic [ADDR_W-1:0]   branch_offset,
   input  logic [ADDR_W-1:0]   jump_target,
   if_fetch_unit_if.master     imem,
   output logic [ADDR_W-1:0]   pc,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [ADDR_W-1:0]   if_id_pc_plus2,
   output logic                if_id_valid,
   output logic                halted,
   output logic                error_halt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t               state_q;
   logic [ADDR_W-1:0]    pc_q;
   logic [INSTR_W-1:0]   if_id_instr_q;
   logic [ADDR_W-1:0]    if_id_pc_plus2_q;
   logic                 if_id_valid_q;
   logic                 halted_q;
   logic                 error_halt_q;
   logic                 discard_q;
   logic                 skid_full_q;
   logic [INSTR_W-1:0]   skid_instr_q;
   logic [ADDR_W-1:0]    skid_pc_plus2_q;

   logic [ADDR_W-1:0]    pc_plus2_d;
   logic [ADDR_W-1:0]    redirect_pc_d;
   logic                 req_d;
   logic                 rsp_d;

   assign pc_plus2_d    = pc_q + {{(ADDR_W-2){1'b0}}, 2'b10};
   assign redirect_pc_d = b_jmp ? (id_pc_plus2 + (branch_offset << 1'd1)) : jump_target;

   // Reset is folded in so no request leaks out while the state register is still settling.
   assign req_d = ~reset & (state_q == ST_RUN) & ~stall & ~skid_full_q & ~pc_op
                & ~halt & ~overflow_error_warning;
   assign rsp_d = (state_q == ST_WAIT) & imem.imem_ready;

   assign imem.imem_req  = req_d;
   assign imem.imem_addr = pc_q;

   assign pc             = pc_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc_plus2 = if_id_pc_plus2_q;
   assign if_id_valid    = if_id_valid_q;
   assign halted         = halted_q;
   assign error_halt     = error_halt_q;

   // Fetch FSM, PC, skid buffer and IF/ID register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_RUN;
         pc_q             <= RESET_PC;
         if_id_instr_q    <= NOP_INSTR;
         if_id_pc_plus2_q <= {ADDR_W{1'b0}};
         if_id_valid_q    <= 1'b0;
         halted_q         <= 1'b0;
         error_halt_q     <= 1'b0;
         discard_q        <= 1'b0;
         skid_full_q      <= 1'b0;
         skid_instr_q     <= NOP_INSTR;
         skid_pc_plus2_q  <= {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            ST_ERROR: begin
               state_q <= ST_ERROR;
            end
            ST_RUN, ST_WAIT, ST_HALTED: begin
               if (overflow_error_warning) begin
                  state_q       <= ST_ERROR;
                  error_halt_q  <= 1'b1;
                  if_id_valid_q <= 1'b0;
                  skid_full_q   <= 1'b0;
                  discard_q     <= 1'b0;
               end else if (halt || (state_q == ST_HALTED)) begin
                  // Any response still in flight is simply never consumed.
                  state_q     <= ST_HALTED;
                  halted_q    <= 1'b1;
                  skid_full_q <= 1'b0;
                  discard_q   <= 1'b0;
                  if (if_flush) begin
                     if_id_valid_q <= 1'b0;
                     if_id_instr_q <= NOP_INSTR;
                  end
               end else begin
                  if (pc_op) begin
                     pc_q        <= redirect_pc_d;
                     skid_full_q <= 1'b0;
                     if (state_q == ST_WAIT) begin
                        if (imem.imem_ready) begin
                           state_q   <= ST_RUN;
                           discard_q <= 1'b0;
                        end else begin
                           discard_q <= 1'b1;
                        end
                     end
                  end else if (rsp_d) begin
                     state_q   <= ST_RUN;
                     discard_q <= 1'b0;
                     if (!discard_q) begin
                        pc_q <= pc_plus2_d;
                        if (stall) begin
                           skid_full_q     <= 1'b1;
                           skid_instr_q    <= imem.imem_rdata;
                           skid_pc_plus2_q <= pc_plus2_d;
                        end else begin
                           if_id_instr_q    <= imem.imem_rdata;
                           if_id_pc_plus2_q <= pc_plus2_d;
                           if_id_valid_q    <= 1'b1;
                        end
                     end
                  end else if (req_d) begin
                     state_q <= ST_WAIT;
                  end else if (skid_full_q && !stall) begin
                     if_id_instr_q    <= skid_instr_q;
                     if_id_pc_plus2_q <= skid_pc_plus2_q;
                     if_id_valid_q    <= 1'b1;
                     skid_full_q      <= 1'b0;
                  end
                  // Flush is written last so it wins over any load or capture above.
                  if (if_flush) begin
                     if_id_valid_q <= 1'b0;
                     if_id_instr_q <= NOP_INSTR;
                     skid_full_q   <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_ERROR;
            end
         endcase
      end
   end

endmodule
